// File: rtl/cpu_mem_arb_pkg.sv
// Shared types for the CPU instruction/data memory arbiter.
// Source tags ride the in-order FIFO so responses find their master.
package cpu_mem_arb_pkg;

   typedef enum logic {
      SRC_INST = 1'b0,
      SRC_DATA = 1'b1
   } src_t;

   typedef struct packed {
      src_t src;
      logic wr;
   } tag_t;

endpackage

// File: rtl/cpu_mem_arbiter_tag_fifo.sv
// In-order tag FIFO for outstanding memory requests.
// A push is accepted at full only when a pop frees a slot in the same cycle.
module arb_tag_fifo
   import cpu_mem_arb_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  tag_t          push_tag,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output tag_t          head,
   output logic [CW-1:0] count
);

   tag_t          mem_q [DEPTH];
   logic [PW-1:0] wr_q;
   logic [PW-1:0] rd_q;
   logic [CW-1:0] cnt_q;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem_q[rd_q];
   assign count   = cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + PW'(1);
         if (do_pop)  rd_q <= rd_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= push_tag;
   end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Merges instruction and data SRAM-like channels onto one in-order memory port.
// Define CPU_MEM_ARB_RR_EN for round-robin arbitration; default is data-first.
module cpu_mem_arbiter
   import cpu_mem_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int OUTSTANDING = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                inst_req,
   input  logic [ADDR_W-1:0]   inst_addr,
   output logic                inst_addr_ok,
   output logic                inst_data_ok,
   output logic [DATA_W-1:0]   inst_rdata,
   input  logic                data_req,
   input  logic                data_wr,
   input  logic [DATA_W/8-1:0] data_wstrb,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic                data_addr_ok,
   output logic                data_data_ok,
   output logic [DATA_W-1:0]   data_rdata,
   output logic                mem_req,
   output logic                mem_wr,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_addr_ok,
   input  logic                mem_data_ok,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int CW = $clog2(OUTSTANDING) + 1;

   src_t          sel;
   logic          sel_req;
   logic          lock_q;
   src_t          lock_src_q;
   logic          hs;
   logic          pop_ok;
   logic          fifo_full;
   logic          fifo_empty;
   tag_t          fifo_head;
   tag_t          push_tag;
   logic [CW-1:0] unused_count;

`ifdef CPU_MEM_ARB_RR_EN
   src_t rr_q;
`endif

   always_comb begin
      sel = SRC_INST;
      if (lock_q) begin
         sel = lock_src_q;
      end else begin
`ifdef CPU_MEM_ARB_RR_EN
         if (inst_req && data_req) sel = rr_q;
         else if (data_req)        sel = SRC_DATA;
`else
         if (data_req) sel = SRC_DATA;
`endif
      end
   end

   assign sel_req = (sel == SRC_DATA) ? data_req : inst_req;
   assign pop_ok  = mem_data_ok & ~fifo_empty & ~reset;

   // A same-cycle pop frees a slot, so a full FIFO still issues then.
   assign mem_req   = sel_req & ~reset & (~fifo_full | pop_ok);
   assign hs        = mem_req & mem_addr_ok;
   assign mem_wr    = (sel == SRC_DATA) & data_wr;
   assign mem_wstrb = (sel == SRC_DATA) ? data_wstrb : '0;
   assign mem_addr  = (sel == SRC_DATA) ? data_addr : inst_addr;
   assign mem_wdata = data_wdata;

   assign inst_addr_ok = hs & (sel == SRC_INST);
   assign data_addr_ok = hs & (sel == SRC_DATA);
   assign inst_data_ok = pop_ok & (fifo_head.src == SRC_INST);
   assign data_data_ok = pop_ok & (fifo_head.src == SRC_DATA);
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   assign push_tag = '{src: sel, wr: mem_wr};

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_q     <= 1'b0;
         lock_src_q <= SRC_DATA;
      end else begin
         lock_q     <= mem_req & ~mem_addr_ok;
         lock_src_q <= sel;
      end
   end

`ifdef CPU_MEM_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (reset)   rr_q <= SRC_DATA;
      else if (hs) rr_q <= (sel == SRC_DATA) ? SRC_INST : SRC_DATA;
   end
`endif

   arb_tag_fifo #(
      .DEPTH (OUTSTANDING)
   ) u_tag_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (hs),
      .push_tag (push_tag),
      .pop      (pop_ok),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .head     (fifo_head),
      .count    (unused_count)
   );

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: issue order, grant lock, full stall,
// response routing and reset flush; RR build checked when its macro is set.
module tb_cpu_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic        data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req;
   logic        mem_wr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   logic [3:0] exp_seq;
   logic       exp_d;

   always #5 clk = ~clk;

   cpu_mem_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_wstrb   (data_wstrb),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .mem_req      (mem_req),
      .mem_wr       (mem_wr),
      .mem_wstrb    (mem_wstrb),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_addr_ok  (mem_addr_ok),
      .mem_data_ok  (mem_data_ok),
      .mem_rdata    (mem_rdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      inst_req    = 1'b0;
      data_req    = 1'b0;
      data_wr     = 1'b0;
      data_wstrb  = 4'h0;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      inst_addr  = '0;
      data_addr  = '0;
      data_wdata = '0;
      mem_rdata  = '0;
      idle();
      tick();
      tick();

      // reset holds everything quiet even with requests present
      inst_req    = 1'b1;
      mem_addr_ok = 1'b1;
      mem_data_ok = 1'b1;
      settle();
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_inst_aok", 32'(inst_addr_ok), 32'd0);
      chk("rst_inst_dok", 32'(inst_data_ok), 32'd0);
      chk("rst_data_dok", 32'(data_data_ok), 32'd0);
      tick();
      reset = 1'b0;
      idle();
      settle();
      chk("idle_mem_req", 32'(mem_req), 32'd0);
      tick();

      // 1: single instruction fetch
      inst_req    = 1'b1;
      inst_addr   = 32'h1c00_0000;
      mem_addr_ok = 1'b1;
      settle();
      chk("t1_mem_req", 32'(mem_req), 32'd1);
      chk("t1_mem_addr", mem_addr, 32'h1c00_0000);
      chk("t1_inst_aok", 32'(inst_addr_ok), 32'd1);
      chk("t1_data_aok", 32'(data_addr_ok), 32'd0);
      chk("t1_wstrb", 32'(mem_wstrb), 32'd0);
      chk("t1_wr", 32'(mem_wr), 32'd0);
      tick();
      idle();
      settle();
      chk("t1_gap_req", 32'(mem_req), 32'd0);
      chk("t1_gap_dok", 32'(inst_data_ok), 32'd0);
      tick();
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h0280_0c0c;
      settle();
      chk("t1_inst_dok", 32'(inst_data_ok), 32'd1);
      chk("t1_inst_rdata", inst_rdata, 32'h0280_0c0c);
      chk("t1_data_dok", 32'(data_data_ok), 32'd0);
      tick();
      // stray response with nothing outstanding
      settle();
      chk("stray_inst_dok", 32'(inst_data_ok), 32'd0);
      chk("stray_data_dok", 32'(data_data_ok), 32'd0);
      tick();
      idle();

      // 2: simultaneous requests, data first
      inst_req    = 1'b1;
      inst_addr   = 32'h1c00_0004;
      data_req    = 1'b1;
      data_wr     = 1'b1;
      data_wstrb  = 4'hf;
      data_addr   = 32'h0000_00a0;
      data_wdata  = 32'hdead_beef;
      mem_addr_ok = 1'b1;
      settle();
      chk("t2_addr_d", mem_addr, 32'h0000_00a0);
      chk("t2_wr_d", 32'(mem_wr), 32'd1);
      chk("t2_wstrb_d", 32'(mem_wstrb), 32'hf);
      chk("t2_wdata_d", mem_wdata, 32'hdead_beef);
      chk("t2_data_aok", 32'(data_addr_ok), 32'd1);
      chk("t2_inst_aok0", 32'(inst_addr_ok), 32'd0);
      tick();
      data_req = 1'b0;
      settle();
      chk("t2_addr_i", mem_addr, 32'h1c00_0004);
      chk("t2_inst_aok", 32'(inst_addr_ok), 32'd1);
      chk("t2_wstrb_i", 32'(mem_wstrb), 32'd0);
      tick();
      idle();
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h1111_1111;
      settle();
      chk("t2_first_ddok", 32'(data_data_ok), 32'd1);
      chk("t2_first_idok", 32'(inst_data_ok), 32'd0);
      tick();
      mem_rdata = 32'h2222_2222;
      settle();
      chk("t2_second_idok", 32'(inst_data_ok), 32'd1);
      chk("t2_second_ddok", 32'(data_data_ok), 32'd0);
      chk("t2_second_rdata", inst_rdata, 32'h2222_2222);
      tick();
      idle();

      // 3: data stalled, inst arrives late, grant stays on data
      data_req  = 1'b1;
      data_wr   = 1'b0;
      data_addr = 32'h0000_00b0;
      inst_addr = 32'h1c00_0008;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("t3_stall_req", 32'(mem_req), 32'd1);
         chk("t3_stall_addr", mem_addr, 32'h0000_00b0);
         tick();
      end
      inst_req = 1'b1;
      settle();
      chk("t3_lock_addr", mem_addr, 32'h0000_00b0);
      chk("t3_lock_iaok", 32'(inst_addr_ok), 32'd0);
      tick();
      mem_addr_ok = 1'b1;
      settle();
      chk("t3_hs_daok", 32'(data_addr_ok), 32'd1);
      chk("t3_hs_iaok", 32'(inst_addr_ok), 32'd0);
      tick();
      data_req = 1'b0;
      settle();
      chk("t3_inst_addr", mem_addr, 32'h1c00_0008);
      chk("t3_inst_aok", 32'(inst_addr_ok), 32'd1);
      tick();
      idle();
      mem_data_ok = 1'b1;
      settle();
      chk("t3_rsp0_ddok", 32'(data_data_ok), 32'd1);
      tick();
      settle();
      chk("t3_rsp1_idok", 32'(inst_data_ok), 32'd1);
      tick();
      idle();

      // 3b: inst stalled first, a later data request must not steal the grant
      inst_req  = 1'b1;
      inst_addr = 32'h0000_00c0;
      settle();
      chk("t3b_addr_i", mem_addr, 32'h0000_00c0);
      tick();
      data_req  = 1'b1;
      data_addr = 32'h0000_00d0;
      settle();
      chk("t3b_lock_addr", mem_addr, 32'h0000_00c0);
      tick();
      mem_addr_ok = 1'b1;
      settle();
      chk("t3b_iaok", 32'(inst_addr_ok), 32'd1);
      chk("t3b_daok0", 32'(data_addr_ok), 32'd0);
      tick();
      inst_req = 1'b0;
      settle();
      chk("t3b_daok", 32'(data_addr_ok), 32'd1);
      chk("t3b_addr_d", mem_addr, 32'h0000_00d0);
      tick();
      idle();
      mem_data_ok = 1'b1;
      settle();
      chk("t3b_rsp0_idok", 32'(inst_data_ok), 32'd1);
      tick();
      settle();
      chk("t3b_rsp1_ddok", 32'(data_data_ok), 32'd1);
      tick();
      idle();

      // 4: fill to capacity, then stall, then push+pop at full
      inst_req    = 1'b1;
      inst_addr   = 32'h1c00_0100;
      mem_addr_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("t4_fill_iaok", 32'(inst_addr_ok), 32'd1);
         tick();
      end
      data_req  = 1'b1;
      data_wr   = 1'b0;
      data_addr = 32'h0000_0200;
      settle();
      chk("t4_full_req", 32'(mem_req), 32'd0);
      chk("t4_full_iaok", 32'(inst_addr_ok), 32'd0);
      chk("t4_full_daok", 32'(data_addr_ok), 32'd0);
      tick();
      mem_data_ok = 1'b1;
      settle();
      chk("t4_pop_idok", 32'(inst_data_ok), 32'd1);
      chk("t4_pop_req", 32'(mem_req), 32'd1);
      chk("t4_pop_daok", 32'(data_addr_ok), 32'd1);
      tick();
      mem_data_ok = 1'b0;
      settle();
      chk("t4_still_full", 32'(mem_req), 32'd0);
      tick();
      idle();
      mem_data_ok = 1'b1;
      exp_seq     = 4'b1000;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("t4_drain_ddok", 32'(data_data_ok), 32'(exp_seq[i]));
         chk("t4_drain_idok", 32'(inst_data_ok), 32'(!exp_seq[i]));
         tick();
      end
      idle();

      // 6: reset with two outstanding, later response is dropped
      inst_req    = 1'b1;
      mem_addr_ok = 1'b1;
      tick();
      tick();
      idle();
      reset = 1'b1;
      tick();
      reset       = 1'b0;
      mem_data_ok = 1'b1;
      settle();
      chk("t6_drop_idok", 32'(inst_data_ok), 32'd0);
      chk("t6_drop_ddok", 32'(data_data_ok), 32'd0);
      tick();
      idle();

      // 5: both masters requesting continuously from a clean state
      inst_req    = 1'b1;
      data_req    = 1'b1;
      mem_addr_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
`ifdef CPU_MEM_ARB_RR_EN
         exp_d = (i % 2 == 0);
`else
         exp_d = 1'b1;
`endif
         settle();
         chk("t5_daok", 32'(data_addr_ok), 32'(exp_d));
         chk("t5_iaok", 32'(inst_addr_ok), 32'(!exp_d));
         tick();
      end
      settle();
      chk("t5_full_req", 32'(mem_req), 32'd0);
      tick();
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
